// File: rtl/theta_gamma_if.sv
`default_nettype none
// ============================================================================
// Module      : theta_gamma_if
// Description : Control and status bundle of the theta/gamma sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface theta_gamma_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             pause;
  logic [CNT_W-1:0] cfg_gamma_len;
  logic             gamma_tick;
  logic             theta_tick;
  logic [2:0]       gamma_idx;
  logic [7:0]       theta_count;
  logic             busy;

  modport master (
    output start, stop, pause, cfg_gamma_len,
    input  gamma_tick, theta_tick, gamma_idx, theta_count, busy
  );

  modport slave (
    input  start, stop, pause, cfg_gamma_len,
    output gamma_tick, theta_tick, gamma_idx, theta_count, busy
  );
endinterface
`default_nettype wire

// File: rtl/theta_gamma_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : theta_gamma_sequencer
// Description : Generates gamma-slot and theta-episode ticks with pause/stop.
// Revision    : 1.0 - initial release
// ============================================================================
module theta_gamma_sequencer #(
  parameter int GAMMA_LEN_DEF    = 16,
  parameter int GAMMAS_PER_THETA = 8,
  parameter int CNT_W            = 8
) (
  input  logic         clk,
  input  logic         rst,
  theta_gamma_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_PAUSED   = 2'd2,
    S_STOPPING = 2'd3
  } state_t;

  localparam logic [2:0]       c_last_idx = 3'(GAMMAS_PER_THETA - 1);
  localparam logic [CNT_W-1:0] c_len_def  = CNT_W'(GAMMA_LEN_DEF);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_two      = CNT_W'(2);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_ph, w_ph_nxt;
  logic [CNT_W-1:0] r_len, w_len_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_theta_cnt, w_theta_cnt_nxt;
  logic             r_stop_pend, w_stop_pend_nxt;
  logic             w_active, w_stopping, w_slot_end, w_theta;

  // PAUSED with pause released behaves as the remembered state, so a pause of
  // N clocks delays every later tick by exactly N clocks.
  assign w_active   = !bus.pause && (r_state != S_IDLE);
  assign w_stopping = (r_state == S_STOPPING) || ((r_state == S_PAUSED) && r_stop_pend);
  assign w_slot_end = (r_ph == (r_len - c_one));
  assign w_theta    = w_active && w_slot_end && (r_idx == c_last_idx);

  assign bus.gamma_tick  = w_active && (r_ph == '0);
  assign bus.theta_tick  = w_theta;
  assign bus.gamma_idx   = r_idx;
  assign bus.theta_count = r_theta_cnt;
  assign bus.busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ph        <= '0;
      r_idx       <= '0;
      r_theta_cnt <= '0;
      r_len       <= c_len_def;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ph        <= w_ph_nxt;
      r_idx       <= w_idx_nxt;
      r_theta_cnt <= w_theta_cnt_nxt;
      r_len       <= w_len_nxt;
      r_stop_pend <= w_stop_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ph_nxt        = r_ph;
    w_idx_nxt       = r_idx;
    w_theta_cnt_nxt = r_theta_cnt;
    w_len_nxt       = r_len;
    w_stop_pend_nxt = r_stop_pend;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_ph_nxt    = '0;
          w_idx_nxt   = '0;
          w_len_nxt   = (bus.cfg_gamma_len >= c_two) ? bus.cfg_gamma_len : c_len_def;
        end
      end
      default: begin
        if (bus.pause) begin
          // A stop seen before or during the pause is kept for the resume.
          w_state_nxt     = S_PAUSED;
          w_stop_pend_nxt = w_stopping || bus.stop;
        end else begin
          w_stop_pend_nxt = 1'b0;
          if (w_slot_end) begin
            w_ph_nxt  = '0;
            w_idx_nxt = (r_idx == c_last_idx) ? 3'd0 : r_idx + 3'd1;
          end else begin
            w_ph_nxt = r_ph + c_one;
          end
          if (w_theta) begin
            w_theta_cnt_nxt = r_theta_cnt + 8'd1;
          end
          if (w_theta && w_stopping) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = (w_stopping || bus.stop) ? S_STOPPING : S_RUN;
          end
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_theta_gamma_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_theta_gamma_sequencer
// Description : Directed self-checking bench for theta_gamma_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_theta_gamma_sequencer;

  logic clk;
  logic rst;

  theta_gamma_if #(.CNT_W(8)) bus ();

  theta_gamma_sequencer #(
    .GAMMA_LEN_DEF   (16),
    .GAMMAS_PER_THETA(8),
    .CNT_W           (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_pass  = 0;
  int         cyc     = 0;
  int         g_q[$];
  int         t_q[$];
  bit         busy_log[0:511];
  logic [2:0] idx_log[0:511];
  bit         overlap_seen = 1'b0;
  logic [7:0] exp_tc = 8'd0;

  // Cycle n is the clock interval following the n-th rising edge after start.
  always @(negedge clk) begin
    if (cyc < 512) begin
      busy_log[cyc] = bus.busy;
      idx_log[cyc]  = bus.gamma_idx;
    end
    if (bus.gamma_tick) g_q.push_back(cyc);
    if (bus.theta_tick) t_q.push_back(cyc);
    if (bus.gamma_tick && bus.theta_tick) overlap_seen = 1'b1;
    cyc = cyc + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [7:0] cfg, input logic stp);
    bus.start         = 1'b1;
    bus.stop          = stp;
    bus.cfg_gamma_len = cfg;
    g_q.delete();
    t_q.delete();
    cyc = 0;
    step(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit timed_out);
    int n = 0;
    while (bus.busy && n < bound) begin
      step(1);
      n++;
    end
    timed_out = bus.busy;
    step(2);
  endtask

  function automatic bit q_eq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset;
    step(2);
    n_total++;
    if ({bus.busy, bus.gamma_tick, bus.theta_tick} !== 3'b000)
      $display("FAIL reset_flags: got %b, want 000", {bus.busy, bus.gamma_tick, bus.theta_tick});
    else n_pass++;
    n_total++;
    if ({bus.gamma_idx, bus.theta_count} !== 11'd0)
      $display("FAIL reset_counts: got idx=%0d tc=%0d, want 0/0", bus.gamma_idx, bus.theta_count);
    else n_pass++;
    rst = 1'b0;
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    step(3);
    n_total++;
    if (bus.busy !== 1'b0 || bus.gamma_tick !== 1'b0)
      $display("FAIL idle_after_reset: got busy=%b gtick=%b, want 0/0", bus.busy, bus.gamma_tick);
    else n_pass++;
  endtask

  task automatic test_basic;
    int e[$];
    bit to;
    kick(8'd4, 1'b0);
    step(33);
    for (int k = 0; k < 9; k++) e.push_back(1 + 4 * k);
    n_total++;
    if (!q_eq(g_q, e)) $display("FAIL basic_gamma: got %p, want %p", g_q, e);
    else n_pass++;
    e = '{32};
    n_total++;
    if (!q_eq(t_q, e)) $display("FAIL basic_theta: got %p, want %p", t_q, e);
    else n_pass++;
    exp_tc = exp_tc + 8'd1;
    n_total++;
    if (bus.theta_count !== exp_tc) $display("FAIL basic_count: got %0d, want %0d", bus.theta_count, exp_tc);
    else n_pass++;
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    wait_idle(100, to);
    exp_tc = exp_tc + 8'd1;
    e = '{32, 64};
    n_total++;
    if (to || !q_eq(t_q, e) || bus.theta_count !== exp_tc)
      $display("FAIL basic_stop: got timeout=%0b theta=%p tc=%0d, want 0 %p %0d", to, t_q, bus.theta_count, e, exp_tc);
    else n_pass++;
  endtask

  task automatic test_default_len;
    int e[$];
    bit to;
    kick(8'd1, 1'b0);
    step(129);
    for (int k = 0; k < 9; k++) e.push_back(1 + 16 * k);
    n_total++;
    if (!q_eq(g_q, e)) $display("FAIL deflen_gamma: got %p, want %p", g_q, e);
    else n_pass++;
    e = '{128};
    n_total++;
    if (!q_eq(t_q, e)) $display("FAIL deflen_theta: got %p, want %p", t_q, e);
    else n_pass++;
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    wait_idle(300, to);
    exp_tc = exp_tc + 8'd2;
    e = '{128, 256};
    n_total++;
    if (to || !q_eq(t_q, e) || bus.theta_count !== exp_tc)
      $display("FAIL deflen_stop: got timeout=%0b theta=%p tc=%0d, want 0 %p %0d", to, t_q, bus.theta_count, e, exp_tc);
    else n_pass++;
  endtask

  task automatic test_stop;
    int e[$];
    bit all_busy = 1'b1;
    kick(8'd4, 1'b0);
    step(9);
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    step(30);
    for (int c = 1; c <= 32; c++) all_busy &= busy_log[c];
    n_total++;
    if (!all_busy || busy_log[33] !== 1'b0)
      $display("FAIL stop_busy: got busy1..32=%0b busy33=%0b, want 1/0", all_busy, busy_log[33]);
    else n_pass++;
    for (int k = 0; k < 8; k++) e.push_back(1 + 4 * k);
    n_total++;
    if (!q_eq(g_q, e)) $display("FAIL stop_gamma: got %p, want %p", g_q, e);
    else n_pass++;
    e = '{32};
    exp_tc = exp_tc + 8'd1;
    n_total++;
    if (!q_eq(t_q, e) || bus.theta_count !== exp_tc)
      $display("FAIL stop_theta: got %p tc=%0d, want %p tc=%0d", t_q, bus.theta_count, e, exp_tc);
    else n_pass++;
  endtask

  task automatic test_pause;
    int e[$];
    bit to;
    bit frozen = 1'b1;
    kick(8'd4, 1'b0);
    step(5);
    bus.pause = 1'b1;
    step(4);
    bus.pause = 1'b0;
    step(30);
    bus.pause = 1'b1;
    step(1);
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    step(1);
    bus.pause = 1'b0;
    wait_idle(100, to);
    for (int c = 5; c <= 10; c++) frozen &= (idx_log[c] == 3'd1);
    n_total++;
    if (!frozen || idx_log[12] !== 3'd1 || idx_log[13] !== 3'd2)
      $display("FAIL pause_idx: got frozen=%0b idx12=%0d idx13=%0d, want 1/1/2", frozen, idx_log[12], idx_log[13]);
    else n_pass++;
    e = '{1, 5};
    for (int k = 0; k < 6; k++) e.push_back(13 + 4 * k);
    e.push_back(37);
    for (int k = 0; k < 7; k++) e.push_back(44 + 4 * k);
    n_total++;
    if (!q_eq(g_q, e)) $display("FAIL pause_gamma: got %p, want %p", g_q, e);
    else n_pass++;
    e = '{36, 71};
    exp_tc = exp_tc + 8'd2;
    n_total++;
    if (to || !q_eq(t_q, e) || bus.theta_count !== exp_tc)
      $display("FAIL pause_theta: got timeout=%0b %p tc=%0d, want 0 %p %0d", to, t_q, bus.theta_count, e, exp_tc);
    else n_pass++;
    n_total++;
    if (busy_log[71] !== 1'b1 || busy_log[72] !== 1'b0)
      $display("FAIL pause_stop_busy: got %0b%0b, want 10", busy_log[71], busy_log[72]);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int e[$];
    bit to;
    kick(8'd4, 1'b1);
    step(11);
    bus.start = 1'b1;
    bus.cfg_gamma_len = 8'd2;
    step(1);
    bus.start = 1'b0;
    bus.cfg_gamma_len = 8'd7;
    step(21);
    for (int k = 0; k < 9; k++) e.push_back(1 + 4 * k);
    n_total++;
    if (!q_eq(g_q, e) || bus.busy !== 1'b1)
      $display("FAIL b2b_gamma: got %p busy=%0b, want %p busy=1", g_q, bus.busy, e);
    else n_pass++;
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    wait_idle(100, to);
    exp_tc = exp_tc + 8'd2;
    e = '{32, 64};
    n_total++;
    if (to || !q_eq(t_q, e) || bus.theta_count !== exp_tc)
      $display("FAIL b2b_theta: got timeout=%0b %p tc=%0d, want 0 %p %0d", to, t_q, bus.theta_count, e, exp_tc);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    kick(8'd4, 1'b0);
    step(19);
    n_total++;
    if (bus.gamma_idx !== 3'd4) $display("FAIL rstmid_pre_idx: got %0d, want 4", bus.gamma_idx);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    exp_tc = 8'd0;
    n_total++;
    if ({bus.busy, bus.gamma_tick, bus.theta_tick, bus.gamma_idx} !== 6'd0 || bus.theta_count !== exp_tc)
      $display("FAIL rstmid_async: got busy=%0b idx=%0d tc=%0d, want 0/0/0", bus.busy, bus.gamma_idx, bus.theta_count);
    else n_pass++;
    step(2);
    rst = 1'b0;
    step(20);
    n_total++;
    if (t_q.size() != 0 || g_q.size() != 5 || bus.busy !== 1'b0)
      $display("FAIL rstmid_after: got thetas=%0d gammas=%0d busy=%0b, want 0/5/0", t_q.size(), g_q.size(), bus.busy);
    else n_pass++;
  endtask

  task automatic test_no_overlap;
    n_total++;
    if (overlap_seen !== 1'b0) $display("FAIL tick_overlap: got %0b, want 0", overlap_seen);
    else n_pass++;
  endtask

  initial begin
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.pause         = 1'b0;
    bus.cfg_gamma_len = 8'd0;
    test_reset;
    test_basic;
    test_default_len;
    test_stop;
    test_pause;
    test_back_to_back;
    test_reset_mid;
    test_no_overlap;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
